ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage pipeline, between the OF/EX latch and the EX/MA latch. Computes the ALU result, holds the E/GT flags register, resolves branches, and runs an iterative signed divider for div/mod that stalls the front end until the quotient or remainder is ready. The surrounding pipeline latches update on the falling edge of `clk`; every sequential element in this block does too.

## Interface
- `WIDTH`, default 32: datapath width; only 32 is supported.
- `clk  in  1`: pipeline clock. All state updates on the falling edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `input_EX_PC  in  32`: PC of the instruction in EX.
- `EX_branchTarget  in  32`: precomputed branch target.
- `Operand_EX_A  in  32`: ALU operand A (rs1).
- `Operand_EX_B  in  32`: ALU operand B, with the immediate already selected upstream.
- `Operand_EX_2  in  32`: store data, passed through.
- `input_EX_IR  in  32`: instruction word. `32'h68000000` is a NOP.
- `Input_EX_controlBus  in  22`: decoded controls. Bit order 0..21:
  - 0–8: isSt, isLd, isBeq, isBgt, isRet, isImmediate, isWb, isUbranch, isCall
  - 9–21: isAdd, isSub, isCmp, isMul, isDiv, isMod, isLsl, isLsr, isAsr, isOr, isAnd, isNot, isMov
- `EX_aluResult  out  32`: result for the EX/MA latch.
- `EX_branchPC  out  32`: redirect PC.
- `EX_isBranchTaken  out  1`: redirect request.
- `EX_stall  out  1`: while high, the PC, IF/OF and OF/EX latches hold and the EX/MA latch loads a NOP.
- `EX_flags  out  2`: `{GT,E}` register.

## Operation
- ALU result selection:
  - add, ld, st: A+B.
  - sub: A−B.
  - cmp: A−B (result not written back).
  - mul: low 32 bits of the signed product.
  - lsl/lsr/asr: shift A by B[4:0].
  - or, and.
  - not: ~B.
  - mov: B.
  - No op bit set: 0.
- Flags:
  - On a falling edge with isCmp=1 and EX_stall=0: E ← (A==B), GT ← ($signed(A) > $signed(B)).
  - Otherwise the flags hold.
- Branch resolution (combinational, gated by EX_stall=0):
  - `EX_isBranchTaken` = isUbranch | (isBeq & E) | (isBgt & GT).
  - `EX_branchPC` = isRet ? A : EX_branchTarget.
- Divider FSM, states IDLE, BUSY, DONE:
  - **IDLE:** when isDiv|isMod is set, EX_stall=1. At the next falling edge, latch the absolute values and signs, clear the 6-bit counter, and go to BUSY.
  - **BUSY:** one restoring quotient bit per edge. After 32 iterations (counter==31 at the edge), go to DONE. EX_stall=1 throughout.
  - **DONE:** EX_stall=0. EX_aluResult = quotient (div) or remainder (mod) with signs applied; the remainder takes the sign of the dividend. DONE → IDLE unconditionally at the next falling edge.
- Divider special cases:
  - Divide by zero: quotient 32'hFFFFFFFF, remainder = A. Still takes the full latency.
  - 32'h80000000 / −1: quotient 32'h80000000, remainder 0.
- Reset (any time, including mid-division):
  - State → IDLE, counter 0, flags 2'b00.
  - EX_stall=0, EX_isBranchTaken=0, EX_aluResult=0, EX_branchPC=0. All outputs 0 while rst_n is low.

## Timing
- Non-divide ops: zero latency. Results are combinational from the latched inputs and valid before the next falling edge.
- A cmp at edge N is visible to a beq/bgt entering EX at edge N.
- Divide latency:
  - Div enters at edge E0. EX_stall is high from E0 until E33, which is 33 cycles.
  - The DONE result is captured by the EX/MA latch at E34. The next instruction enters EX at E34.
- Back-to-back divides: the second divide sees IDLE after E34 and stalls again. There are no idle bubbles besides the stall cycles.
- A branch is never taken while EX_stall=1.

## Configuration
- `EX_DIVIDER_EN`:
  - Defined: the iterative divider and FSM are built as above.
  - Undefined: div/mod give EX_aluResult=0, EX_stall is tied to 0, and no FSM registers exist.

## Test plan
- add A=5, B=7 → EX_aluResult=12, EX_stall=0, no branch.
- cmp A=3, B=3, then beq with target 0x40 → flags=01, EX_isBranchTaken=1, EX_branchPC=0x40. With A=4, B=3 → flags=10, beq not taken, bgt taken.
- div A=−7, B=2 → EX_stall high for exactly 33 cycles, EX_aluResult=−3 at the capture edge. Same operands with mod → −1.
- div by 0 with A=9 → quotient 0xFFFFFFFF. mod by 0 → 9. Both take the full latency.
- Assert rst_n low at BUSY iteration 10 → EX_stall, flags and outputs go to 0 immediately. After release, a new add completes with no stall.
- ret with A=0x100 → EX_isBranchTaken=0 (ret is not in the taken equation), EX_branchPC=0x100. isUbranch=1 → taken regardless of flags.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: ALU, {GT,E} flags, branch resolution and an iterative signed divider.
// The divider and its FSM are built only when EX_DIVIDER_EN is defined; state updates on negedge clk.
module ex_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] input_EX_PC,
  input  logic [WIDTH-1:0] EX_branchTarget,
  input  logic [WIDTH-1:0] Operand_EX_A,
  input  logic [WIDTH-1:0] Operand_EX_B,
  input  logic [WIDTH-1:0] Operand_EX_2,
  input  logic [WIDTH-1:0] input_EX_IR,
  input  logic [21:0]      Input_EX_controlBus,
  output logic [WIDTH-1:0] EX_aluResult,
  output logic [WIDTH-1:0] EX_branchPC,
  output logic             EX_isBranchTaken,
  output logic             EX_stall,
  output logic [1:0]       EX_flags
);

  logic is_st, is_ld, is_beq, is_bgt, is_ret, is_ubranch;
  logic is_add, is_sub, is_cmp, is_mul, is_div, is_mod;
  logic is_lsl, is_lsr, is_asr, is_or, is_and, is_not, is_mov;

  assign is_st      = Input_EX_controlBus[0];
  assign is_ld      = Input_EX_controlBus[1];
  assign is_beq     = Input_EX_controlBus[2];
  assign is_bgt     = Input_EX_controlBus[3];
  assign is_ret     = Input_EX_controlBus[4];
  assign is_ubranch = Input_EX_controlBus[7];
  assign is_add     = Input_EX_controlBus[9];
  assign is_sub     = Input_EX_controlBus[10];
  assign is_cmp     = Input_EX_controlBus[11];
  assign is_mul     = Input_EX_controlBus[12];
  assign is_div     = Input_EX_controlBus[13];
  assign is_mod     = Input_EX_controlBus[14];
  assign is_lsl     = Input_EX_controlBus[15];
  assign is_lsr     = Input_EX_controlBus[16];
  assign is_asr     = Input_EX_controlBus[17];
  assign is_or      = Input_EX_controlBus[18];
  assign is_and     = Input_EX_controlBus[19];
  assign is_not     = Input_EX_controlBus[20];
  assign is_mov     = Input_EX_controlBus[21];

  // PC, store data, IR and the immediate/writeback/call controls are consumed by later stages.
  logic unused_inputs;
  assign unused_inputs = ^{input_EX_PC, Operand_EX_2, input_EX_IR, Input_EX_controlBus[5],
                           Input_EX_controlBus[6], Input_EX_controlBus[8]};

  logic [WIDTH-1:0] a, b;
  assign a = Operand_EX_A;
  assign b = Operand_EX_B;

  logic             div_stall;
  logic [WIDTH-1:0] div_result;

`ifdef EX_DIVIDER_EN
  typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

  div_state_e       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH:0]   trial;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvsr_q     <= dvsr_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      div_zero_q <= div_zero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvsr_d     = dvsr_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    div_zero_d = div_zero_q;
    div_stall  = 1'b0;
    // Restoring step: quo_q doubles as the dividend shift register.
    trial      = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvsr_q};
    unique case (state_q)
      StIdle: begin
        if (is_div || is_mod) begin
          div_stall  = 1'b1;
          state_d    = StBusy;
          cnt_d      = '0;
          quo_d      = a[WIDTH-1] ? -a : a;
          dvsr_d     = b[WIDTH-1] ? -b : b;
          rem_d      = '0;
          q_neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
          r_neg_d    = a[WIDTH-1];
          div_zero_d = (b == '0);
        end
      end
      StBusy: begin
        div_stall = 1'b1;
        cnt_d     = cnt_q + 6'd1;
        if (trial[WIDTH]) begin
          rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        end else begin
          rem_d = trial[WIDTH-1:0];
        end
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        if (cnt_q == 6'd31) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  logic [WIDTH-1:0] quo_res, rem_res;
  // Operands are held by the stalled OF/EX latch, so A is still valid for the /0 remainder.
  assign quo_res = div_zero_q ? '1 : (q_neg_q ? -quo_q : quo_q);
  assign rem_res = div_zero_q ? a : (r_neg_q ? -rem_q : rem_q);
  assign div_result = (state_q != StDone) ? '0 : (is_mod ? rem_res : quo_res);
`else
  assign div_stall  = 1'b0;
  assign div_result = '0;
`endif

  logic [WIDTH-1:0] alu_raw;

  always_comb begin
    alu_raw = '0;
    if (is_add || is_ld || is_st) begin
      alu_raw = a + b;
    end else if (is_sub || is_cmp) begin
      alu_raw = a - b;
    end else if (is_mul) begin
      alu_raw = a * b;
    end else if (is_lsl) begin
      alu_raw = a << b[4:0];
    end else if (is_lsr) begin
      alu_raw = a >> b[4:0];
    end else if (is_asr) begin
      alu_raw = $unsigned($signed(a) >>> b[4:0]);
    end else if (is_or) begin
      alu_raw = a | b;
    end else if (is_and) begin
      alu_raw = a & b;
    end else if (is_not) begin
      alu_raw = ~b;
    end else if (is_mov) begin
      alu_raw = b;
    end else if (is_div || is_mod) begin
      alu_raw = div_result;
    end
  end

  logic flag_e_q, flag_gt_q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_e_q  <= 1'b0;
      flag_gt_q <= 1'b0;
    end else if (is_cmp && !EX_stall) begin
      flag_e_q  <= (a == b);
      flag_gt_q <= ($signed(a) > $signed(b));
    end
  end

  assign EX_flags         = {flag_gt_q, flag_e_q};
  assign EX_stall         = rst_n & div_stall;
  assign EX_aluResult     = rst_n ? alu_raw : '0;
  assign EX_branchPC      = !rst_n ? '0 : (is_ret ? a : EX_branchTarget);
  assign EX_isBranchTaken = rst_n & ~div_stall &
                            (is_ubranch | (is_beq & flag_e_q) | (is_bgt & flag_gt_q));

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, randomized ops against a reference model,
// divider latency/result sequences (when EX_DIVIDER_EN is defined) and reset during a divide.
module tb_ex_stage;

  localparam logic [31:0] NopIr = 32'h68000000;
  localparam int BitSt = 0, BitLd = 1, BitBeq = 2, BitBgt = 3, BitRet = 4, BitImm = 5;
  localparam int BitWb = 6, BitUbr = 7, BitAdd = 9, BitSub = 10, BitCmp = 11, BitMul = 12;
  localparam int BitDiv = 13, BitMod = 14, BitLsl = 15, BitLsr = 16, BitAsr = 17, BitOr = 18;
  localparam int BitAnd = 19, BitNot = 20, BitMov = 21;

  logic        clk, rst_n;
  logic [31:0] pc, tgt, a, b, op2, ir;
  logic [21:0] ctrl;
  logic [31:0] alu, bpc;
  logic        taken, stall;
  logic [1:0]  flags;

  int n_vec = 0;
  int n_err = 0;

  ex_stage #(.WIDTH(32)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .input_EX_PC         (pc),
    .EX_branchTarget     (tgt),
    .Operand_EX_A        (a),
    .Operand_EX_B        (b),
    .Operand_EX_2        (op2),
    .input_EX_IR         (ir),
    .Input_EX_controlBus (ctrl),
    .EX_aluResult        (alu),
    .EX_branchPC         (bpc),
    .EX_isBranchTaken    (taken),
    .EX_stall            (stall),
    .EX_flags            (flags)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  typedef struct packed {
    logic [21:0] ctrl;
    logic [31:0] a, b, tgt, alu, bpc;
    logic        taken;
    logic [1:0]  flags;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [21:0] op(input int idx);
    return 22'd1 << idx;
  endfunction

  function automatic vec_t mk(input logic [21:0] c, input logic [31:0] va, vb, vt, ealu, ebpc,
                              input logic et, input logic [1:0] ef);
    vec_t v;
    v.ctrl = c; v.a = va; v.b = vb; v.tgt = vt;
    v.alu = ealu; v.bpc = ebpc; v.taken = et; v.flags = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change just after the falling edge, as if loaded by the OF/EX latch.
  task automatic drive(input logic [21:0] c, input logic [31:0] va, vb, vt);
    @(negedge clk);
    #1;
    ctrl = c;
    a    = va;
    b    = vb;
    tgt  = vt;
    pc   = pc + 32'd4;
    op2  = $urandom;
    ir   = (c == '0) ? NopIr : $urandom;
  endtask

  // Reference ALU written from the operation list, indexed by control bit.
  function automatic logic [31:0] model_alu(input int idx, input logic [31:0] x, y);
    int     sx = x;
    int     sy = y;
    int     sh = int'(y % 32);
    longint prod;
    case (idx)
      BitAdd, BitLd, BitSt: return x + y;
      BitSub, BitCmp:       return x - y;
      BitMul: begin
        prod = longint'(sx) * longint'(sy);
        return prod[31:0];
      end
      BitLsl: return x << sh;
      BitLsr: return x >> sh;
      BitAsr: return sx >>> sh;
      BitOr:  return x | y;
      BitAnd: return x & y;
      BitNot: return ~y;
      BitMov: return y;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_div(input bit m, input logic [31:0] x, y);
    int sx = x;
    int sy = y;
    if (y == 32'h0) return m ? x : 32'hFFFFFFFF;
    if (x == 32'h80000000 && y == 32'hFFFFFFFF) return m ? 32'h0 : 32'h80000000;
    return m ? sx % sy : sx / sy;
  endfunction

`ifdef EX_DIVIDER_EN
  task automatic div_run(input string name, input bit m, input bit ubr, input logic [31:0] x, y);
    logic [31:0] exp;
    int          cyc;
    int          bad_taken;
    exp = model_div(m, x, y);
    drive(op(m ? BitMod : BitDiv) | (ubr ? op(BitUbr) : 22'd0), x, y, 32'h300);
    cyc = 0;
    bad_taken = 0;
    @(posedge clk);
    while (stall === 1'b1 && cyc < 100) begin
      if (taken !== 1'b0) bad_taken++;
      cyc++;
      @(posedge clk);
    end
    check({name, " stall_cycles"}, cyc, 33);
    check({name, " result"}, alu, exp);
    check({name, " taken_while_stalled"}, bad_taken, 0);
    check({name, " taken_done"}, {31'd0, taken}, {31'd0, ubr});
  endtask
`endif

  logic [1:0] mf;
  int         idx;
  logic [31:0] ra, rb, rt, ealu;
  logic        etaken;
  int          ops[] = '{BitAdd, BitSub, BitCmp, BitMul, BitLsl, BitLsr, BitAsr, BitOr, BitAnd,
                         BitNot, BitMov, BitLd, BitSt, BitBeq, BitBgt, BitUbr, BitRet, BitCmp,
                         BitCmp, -1};

  initial begin
    rst_n = 1'b0;
    pc    = 32'h0;
    op2   = 32'h0;
    ir    = NopIr;
    ctrl  = op(BitUbr) | op(BitAdd);
    a     = 32'd5;
    b     = 32'd7;
    tgt   = 32'h40;

    // Outputs must be forced to zero while held in reset.
    #3;
    check("reset alu", alu, 32'h0);
    check("reset taken", {31'd0, taken}, 32'h0);
    check("reset bpc", bpc, 32'h0);
    check("reset stall", {31'd0, stall}, 32'h0);
    check("reset flags", {30'd0, flags}, 32'h0);
    #9 rst_n = 1'b1;

    vecs.push_back(mk(op(BitAdd), 5, 7, 32'h40, 12, 32'h40, 0, 2'b00));
    vecs.push_back(mk(op(BitCmp), 3, 3, 32'h40, 0, 32'h40, 0, 2'b00));
    vecs.push_back(mk(op(BitBeq), 0, 0, 32'h40, 0, 32'h40, 1, 2'b01));
    vecs.push_back(mk(op(BitBgt), 0, 0, 32'h40, 0, 32'h40, 0, 2'b01));
    vecs.push_back(mk(op(BitCmp), 4, 3, 32'h40, 1, 32'h40, 0, 2'b01));
    vecs.push_back(mk(op(BitBeq), 0, 0, 32'h40, 0, 32'h40, 0, 2'b10));
    vecs.push_back(mk(op(BitBgt), 0, 0, 32'h80, 0, 32'h80, 1, 2'b10));
    vecs.push_back(mk(op(BitRet), 32'h100, 0, 32'h40, 0, 32'h100, 0, 2'b10));
    vecs.push_back(mk(op(BitUbr), 0, 0, 32'h200, 0, 32'h200, 1, 2'b10));
    vecs.push_back(mk(op(BitSub), 5, 7, 32'h40, 32'hFFFFFFFE, 32'h40, 0, 2'b10));
    vecs.push_back(mk(op(BitMul), 32'hFFFFFFFD, 7, 32'h40, 32'hFFFFFFEB, 32'h40, 0, 2'b10));
    vecs.push_back(mk(op(BitLsl), 1, 35, 32'h40, 8, 32'h40, 0, 2'b10));
    vecs.push_back(mk(op(BitLsr), 32'h80000000, 4, 32'h40, 32'h08000000, 32'h40, 0, 2'b10));
    vecs.push_back(mk(op(BitAsr), 32'h80000000, 4, 32'h40, 32'hF8000000, 32'h40, 0, 2'b10));
    vecs.push_back(mk(op(BitOr), 32'hF0, 32'h0F, 32'h40, 32'hFF, 32'h40, 0, 2'b10));
    vecs.push_back(mk(op(BitAnd), 32'hF0, 32'h3C, 32'h40, 32'h30, 32'h40, 0, 2'b10));
    vecs.push_back(mk(op(BitNot), 9, 0, 32'h40, 32'hFFFFFFFF, 32'h40, 0, 2'b10));
    vecs.push_back(mk(op(BitMov), 9, 32'h1234, 32'h40, 32'h1234, 32'h40, 0, 2'b10));
    vecs.push_back(mk(op(BitLd) | op(BitImm) | op(BitWb), 32'h10, 4, 32'h40, 32'h14, 32'h40, 0,
                      2'b10));
    vecs.push_back(mk(op(BitSt), 32'h10, 4, 32'h40, 32'h14, 32'h40, 0, 2'b10));
    vecs.push_back(mk(22'd0, 5, 7, 32'h40, 0, 32'h40, 0, 2'b10));
    vecs.push_back(mk(op(BitCmp), 32'hFFFFFFFF, 1, 32'h40, 32'hFFFFFFFE, 32'h40, 0, 2'b10));
    vecs.push_back(mk(op(BitBgt), 0, 0, 32'h80, 0, 32'h80, 0, 2'b00));
    vecs.push_back(mk(op(BitBeq), 0, 0, 32'h80, 0, 32'h80, 0, 2'b00));
    vecs.push_back(mk(op(BitCmp), 32'h80000000, 32'h7FFFFFFF, 32'h40, 1, 32'h40, 0, 2'b00));
    vecs.push_back(mk(op(BitBgt), 0, 0, 32'h80, 0, 32'h80, 0, 2'b00));

    foreach (vecs[i]) begin
      drive(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].tgt);
      @(posedge clk);
      check($sformatf("vec%0d alu", i), alu, vecs[i].alu);
      check($sformatf("vec%0d bpc", i), bpc, vecs[i].bpc);
      check($sformatf("vec%0d taken", i), {31'd0, taken}, {31'd0, vecs[i].taken});
      check($sformatf("vec%0d flags", i), {30'd0, flags}, {30'd0, vecs[i].flags});
      check($sformatf("vec%0d stall", i), {31'd0, stall}, 32'h0);
    end

    // Random single-cycle ops; mf tracks the architectural flags.
    mf = 2'b00;
    for (int n = 0; n < 300; n++) begin
      idx = ops[$urandom_range(ops.size() - 1)];
      ra  = $urandom;
      rb  = ($urandom_range(3) == 0) ? ra : $urandom;
      if ($urandom_range(1) == 1) rb = rb & 32'h3F;
      rt  = $urandom;
      ealu = (idx < 0) ? 32'h0 : model_alu(idx, ra, rb);
      etaken = (idx == BitUbr) || (idx == BitBeq && mf[0]) || (idx == BitBgt && mf[1]);
      drive((idx < 0) ? 22'd0 : op(idx), ra, rb, rt);
      @(posedge clk);
      check($sformatf("rnd%0d op%0d alu", n, idx), alu, ealu);
      check($sformatf("rnd%0d taken", n), {31'd0, taken}, {31'd0, etaken});
      check($sformatf("rnd%0d bpc", n), bpc, (idx == BitRet) ? ra : rt);
      check($sformatf("rnd%0d flags", n), {30'd0, flags}, {30'd0, mf});
      if (idx == BitCmp) mf = {($signed(ra) > $signed(rb)), (ra == rb)};
    end

`ifdef EX_DIVIDER_EN
    div_run("div -7/2", 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
    div_run("mod -7%2", 1'b1, 1'b0, 32'hFFFFFFF9, 32'd2);
    div_run("div 9/0", 1'b0, 1'b0, 32'd9, 32'd0);
    div_run("mod 9%0", 1'b1, 1'b0, 32'd9, 32'd0);
    div_run("div min/-1", 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF);
    div_run("mod min/-1", 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF);
    for (int n = 0; n < 6; n++) begin
      ra = $urandom;
      rb = (n % 2 == 0) ? ($urandom & 32'hFF) : $urandom;
      div_run($sformatf("rnd div%0d", n), n[0], 1'b0, ra, rb);
    end
`else
    drive(op(BitDiv), 32'd9, 32'd0, 32'h40);
    @(posedge clk);
    check("nodiv div alu", alu, 32'h0);
    check("nodiv div stall", {31'd0, stall}, 32'h0);
    drive(op(BitMod), 32'hFFFFFFF9, 32'd2, 32'h40);
    @(posedge clk);
    check("nodiv mod alu", alu, 32'h0);
    check("nodiv mod stall", {31'd0, stall}, 32'h0);
`endif

    // Reset asserted with the divider at iteration 10.
    drive(op(BitCmp), 4, 3, 32'h40);
    drive(op(BitDiv) | op(BitUbr), 32'd100, 32'd3, 32'h40);
    repeat (12) @(posedge clk);
`ifdef EX_DIVIDER_EN
    check("busy stall before reset", {31'd0, stall}, 32'h1);
`else
    check("nodiv stall before reset", {31'd0, stall}, 32'h0);
`endif
    check("flags before reset", {30'd0, flags}, 32'h2);
    rst_n = 1'b0;
    #1;
    check("midreset stall", {31'd0, stall}, 32'h0);
    check("midreset flags", {30'd0, flags}, 32'h0);
    check("midreset alu", alu, 32'h0);
    check("midreset taken", {31'd0, taken}, 32'h0);
    check("midreset bpc", bpc, 32'h0);
    #2 rst_n = 1'b1;
    drive(op(BitAdd), 5, 7, 32'h40);
    @(posedge clk);
    check("post-reset add alu", alu, 32'd12);
    check("post-reset add stall", {31'd0, stall}, 32'h0);
    check("post-reset flags", {30'd0, flags}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
